// File: rtl/mvm_mem_arbiter.sv
// mvm_mem_arbiter
//
// Arbitrates three memory requesters (bit0 W loader, bit1 X loader,
// bit2 R store) onto a single memory request port. Responses come back in
// order and are routed to their owner through a 4-entry tag FIFO.
//
// Configuration macro: MVM_ARB_FIXED_PRIO_EN
//   undefined : round-robin, search starts after the last granted requester
//   defined   : fixed priority R (bit2) > X (bit1) > W (bit0)
//
// Ports
//   clk, reset                : clock, synchronous active-low reset
//   req_valid_i / req_ready_o : per-requester valid / one-cycle accept pulse
//   req_addr/cmd/typ/data_i   : packed per-requester request fields
//   resp_valid_o/resp_data_o  : one-hot response strobe + shared data
//   mem_req_*                 : registered request to memory (valid/ready)
//   mem_resp_*                : in-order memory responses
//   outstanding_o             : in-flight request count (0..4)
//   err_o                     : sticky flag, response arrived with no tag
module mvm_mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   req_valid_i,
    output logic [2:0]   req_ready_o,
    input  logic [119:0] req_addr_i,
    input  logic [14:0]  req_cmd_i,
    input  logic [8:0]   req_typ_i,
    input  logic [191:0] req_data_i,
    output logic [2:0]   resp_valid_o,
    output logic [63:0]  resp_data_o,
    input  logic         mem_req_ready_i,
    output logic         mem_req_valid_o,
    output logic [39:0]  mem_req_addr_o,
    output logic [4:0]   mem_req_cmd_o,
    output logic [2:0]   mem_req_typ_o,
    output logic [63:0]  mem_req_data_o,
    input  logic         mem_resp_valid_i,
    input  logic [63:0]  mem_resp_data_i,
    output logic [2:0]   outstanding_o,
    output logic         err_o
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [39:0] addr_q, addr_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [2:0]  typ_q, typ_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  id_q, id_d;
    logic [1:0]  tag_q [4];
    logic [1:0]  tag_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;
`ifndef MVM_ARB_FIXED_PRIO_EN
    logic [1:0]  last_q, last_d;
`endif

    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    logic        grant;
    logic        push;
    logic        pop;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
`ifdef MVM_ARB_FIXED_PRIO_EN
        if (req_valid_i[2]) begin
            gnt_vld = 1'b1;
            gnt_idx = 2'd2;
        end else if (req_valid_i[1]) begin
            gnt_vld = 1'b1;
            gnt_idx = 2'd1;
        end else if (req_valid_i[0]) begin
            gnt_vld = 1'b1;
            gnt_idx = 2'd0;
        end
`else
        // Search starts one past the last winner and wraps 2 -> 0.
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (int'(last_q) + k) % 3;
            if (!gnt_vld && req_valid_i[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = 2'(c);
            end
        end
`endif

        // Reset gates the combinational strobes so nothing is accepted or
        // routed while the block is being cleared.
        grant = reset && (state_q == IDLE) && (count_q != 3'd4) && gnt_vld;
        push  = (state_q == HOLD) && mem_req_ready_i;
        pop   = reset && mem_resp_valid_i && (count_q != 3'd0);

        req_ready_o  = grant ? (3'b001 << gnt_idx) : 3'b000;
        resp_valid_o = pop ? (3'b001 << tag_q[rd_ptr_q]) : 3'b000;
        resp_data_o  = pop ? mem_resp_data_i : 64'd0;

        state_d  = state_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        typ_d    = typ_q;
        data_d   = data_q;
        id_d     = id_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
`ifndef MVM_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif

        if (grant) begin
            state_d = HOLD;
            valid_d = 1'b1;
            addr_d  = req_addr_i[40*gnt_idx +: 40];
            cmd_d   = req_cmd_i[5*gnt_idx +: 5];
            typ_d   = req_typ_i[3*gnt_idx +: 3];
            data_d  = req_data_i[64*gnt_idx +: 64];
            id_d    = gnt_idx;
`ifndef MVM_ARB_FIXED_PRIO_EN
            last_d  = gnt_idx;
`endif
        end

        // Leaving HOLD never overlaps a grant, capping issue at one per two cycles.
        if (push) begin
            state_d          = IDLE;
            valid_d          = 1'b0;
            tag_d[wr_ptr_q]  = id_q;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        count_d = count_q + {2'b00, push} - {2'b00, pop};
        err_d   = err_q | (mem_resp_valid_i && (count_q == 3'd0));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            cmd_q    <= '0;
            typ_q    <= '0;
            data_q   <= '0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifndef MVM_ARB_FIXED_PRIO_EN
            last_q   <= 2'd2;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            typ_q    <= typ_d;
            data_q   <= data_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifndef MVM_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    // Tag storage is only meaningful behind the pointers, so it is not reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign mem_req_valid_o = valid_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_cmd_o   = cmd_q;
    assign mem_req_typ_o   = typ_q;
    assign mem_req_data_o  = data_q;
    assign outstanding_o   = count_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_mvm_mem_arbiter.sv
// tb_mvm_mem_arbiter
//
// Directed scenarios followed by a randomized phase, every cycle compared
// against a transaction-level model: a queue of owner IDs for in-flight
// requests, a "request held" flag with its captured fields, the last winner
// and a sticky error bit. Honors MVM_ARB_FIXED_PRIO_EN like the design.
module tb_mvm_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   req_valid_i;
    logic [2:0]   req_ready_o;
    logic [119:0] req_addr_i;
    logic [14:0]  req_cmd_i;
    logic [8:0]   req_typ_i;
    logic [191:0] req_data_i;
    logic [2:0]   resp_valid_o;
    logic [63:0]  resp_data_o;
    logic         mem_req_ready_i;
    logic         mem_req_valid_o;
    logic [39:0]  mem_req_addr_o;
    logic [4:0]   mem_req_cmd_o;
    logic [2:0]   mem_req_typ_o;
    logic [63:0]  mem_req_data_o;
    logic         mem_resp_valid_i;
    logic [63:0]  mem_resp_data_i;
    logic [2:0]   outstanding_o;
    logic         err_o;

    always #5 clk = ~clk;

    mvm_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_cmd_i        (req_cmd_i),
        .req_typ_i        (req_typ_i),
        .req_data_i       (req_data_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_cmd_o    (mem_req_cmd_o),
        .mem_req_typ_o    (mem_req_typ_o),
        .mem_req_data_o   (mem_req_data_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model
    bit          m_busy;
    logic [39:0] m_addr;
    logic [4:0]  m_cmd;
    logic [2:0]  m_typ;
    logic [63:0] m_data;
    int          m_id;
    int          m_q[$];
    int          m_last;
    bit          m_err;
    int          glog[$];

    function automatic int pick(logic [2:0] v);
`ifdef MVM_ARB_FIXED_PRIO_EN
        if (v[2]) return 2;
        if (v[1]) return 1;
        return 0;
`else
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m_last + k) % 3;
            if (v[i]) return i;
        end
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks all
    // outputs, advances the model across the rising edge, returns at the next
    // falling edge.
    task automatic cycle();
        bit          grant;
        bit          push;
        int          g;
        logic [2:0]  er;
        logic [2:0]  ersp;
        logic [63:0] ed;
        #2;
        grant = reset && !m_busy && (m_q.size() < 4) && (req_valid_i != 3'b000);
        g     = pick(req_valid_i);
        er    = grant ? 3'(1 << g) : 3'b000;
        ersp  = (reset && mem_resp_valid_i && m_q.size() > 0) ? 3'(1 << m_q[0]) : 3'b000;
        ed    = (ersp != 3'b000) ? mem_resp_data_i : 64'd0;
        chk("req_ready", {61'd0, req_ready_o}, {61'd0, er});
        chk("resp_valid", {61'd0, resp_valid_o}, {61'd0, ersp});
        chk("resp_data", resp_data_o, ed);
        chk("mem_req_valid", {63'd0, mem_req_valid_o}, {63'd0, m_busy});
        chk("mem_req_addr", {24'd0, mem_req_addr_o}, {24'd0, m_addr});
        chk("mem_req_cmd", {59'd0, mem_req_cmd_o}, {59'd0, m_cmd});
        chk("mem_req_typ", {61'd0, mem_req_typ_o}, {61'd0, m_typ});
        chk("mem_req_data", mem_req_data_o, m_data);
        chk("outstanding", {61'd0, outstanding_o}, 64'(m_q.size()));
        chk("err", {63'd0, err_o}, {63'd0, m_err});
        if (req_ready_o != 3'b000) glog.push_back(int'(req_ready_o));
        @(posedge clk);
        if (!reset) begin
            m_busy = 1'b0;
            m_q.delete();
            m_last = 2;
            m_err  = 1'b0;
            m_addr = '0;
            m_cmd  = '0;
            m_typ  = '0;
            m_data = '0;
        end else begin
            push = m_busy && mem_req_ready_i;
            if (mem_resp_valid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (push) begin
                m_q.push_back(m_id);
                m_busy = 1'b0;
            end else if (grant) begin
                m_busy = 1'b1;
                m_id   = g;
                m_last = g;
                m_addr = req_addr_i[40*g +: 40];
                m_cmd  = req_cmd_i[5*g +: 5];
                m_typ  = req_typ_i[3*g +: 3];
                m_data = req_data_i[64*g +: 64];
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic randomize_fields();
        req_addr_i = {$urandom, $urandom, $urandom, $urandom};
        req_cmd_i  = 15'($urandom);
        req_typ_i  = 9'($urandom);
        req_data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic int glog_at(int i);
        return (glog.size() > i) ? glog[i] : 0;
    endfunction

    initial begin
        reset            = 1'b0;
        req_valid_i      = 3'b001;
        req_addr_i       = '0;
        req_cmd_i        = '0;
        req_typ_i        = '0;
        req_data_i       = '0;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        m_busy = 0; m_addr = 0; m_cmd = 0; m_typ = 0; m_data = 0;
        m_id = 0; m_last = 2; m_err = 0;
        @(negedge clk);
        // Reset held with a pending request: nothing may be accepted.
        cycle();
        cycle();
        reset = 1'b1;

        // Single load to 0x100
        randomize_fields();
        req_addr_i[39:0] = 40'h100;
        req_cmd_i[4:0]   = 5'd0;
        req_valid_i      = 3'b001;
        cycle();
        req_valid_i = 3'b000;
        chk("t28_valid", {63'd0, mem_req_valid_o}, 64'd1);
        chk("t28_addr", {24'd0, mem_req_addr_o}, 64'h100);
        cycle();
        chk("t28_outstanding", {61'd0, outstanding_o}, 64'd1);
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 64'h1234;
        cycle();
        mem_resp_valid_i = 1'b0;
        cycle();

        // All three requesting, memory always ready
        do_reset();
        glog.delete();
        req_valid_i = 3'b111;
        for (int i = 0; i < 8; i++) cycle();
`ifdef MVM_ARB_FIXED_PRIO_EN
        chk("t29_g0", 64'(glog_at(0)), 64'd4);
        chk("t29_g1", 64'(glog_at(1)), 64'd4);
        chk("t29_g2", 64'(glog_at(2)), 64'd4);
`else
        chk("t29_g0", 64'(glog_at(0)), 64'd1);
        chk("t29_g1", 64'(glog_at(1)), 64'd2);
        chk("t29_g2", 64'(glog_at(2)), 64'd4);
        chk("t29_g3", 64'(glog_at(3)), 64'd1);
`endif

        // FIFO full: no grants until a response frees an entry
        chk("t30_full", {61'd0, outstanding_o}, 64'd4);
        for (int i = 0; i < 3; i++) cycle();
        chk("t30_nogrant", 64'(glog.size()), 64'd4);
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 64'hDEAD;
        cycle();
        mem_resp_valid_i = 1'b0;
        cycle();
        chk("t30_regrant", 64'(glog.size()), 64'd5);
        req_valid_i = 3'b000;
        cycle();
        mem_resp_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_resp_data_i = 64'(i + 100);
            cycle();
        end
        mem_resp_valid_i = 1'b0;
        chk("t30_drained", {61'd0, outstanding_o}, 64'd0);

        // Memory stalls while a request is held
        do_reset();
        randomize_fields();
        mem_req_ready_i = 1'b0;
        req_valid_i     = 3'b010;
        cycle();
        for (int i = 0; i < 5; i++) begin
            randomize_fields();
            req_valid_i = 3'b111;
            cycle();
        end
        req_valid_i     = 3'b000;
        mem_req_ready_i = 1'b1;
        cycle();
        cycle();
        chk("t31_outstanding", {61'd0, outstanding_o}, 64'd1);

        // Orphan response sets the sticky error
        do_reset();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 64'hBEEF;
        cycle();
        mem_resp_valid_i = 1'b0;
        cycle();
        cycle();
        chk("t32_err", {63'd0, err_o}, 64'd1);
        do_reset();
        cycle();
        chk("t32_err_clr", {63'd0, err_o}, 64'd0);

        // Push and pop in the same cycle at two outstanding, then reset in HOLD
        req_valid_i = 3'b001;
        for (int i = 0; i < 5; i++) cycle();
        req_valid_i      = 3'b000;
        mem_resp_valid_i = 1'b1;
        cycle();
        mem_resp_valid_i = 1'b0;
        chk("t33_pushpop", {61'd0, outstanding_o}, 64'd2);
        mem_req_ready_i = 1'b0;
        req_valid_i     = 3'b100;
        cycle();
        req_valid_i = 3'b000;
        do_reset();
        chk("t33_valid_rst", {63'd0, mem_req_valid_o}, 64'd0);
        chk("t33_outst_rst", {61'd0, outstanding_o}, 64'd0);
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b1;
        cycle();
        mem_resp_valid_i = 1'b0;
        chk("t33_err_after_rst", {63'd0, err_o}, 64'd1);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            randomize_fields();
            req_valid_i      = 3'($urandom);
            mem_req_ready_i  = ($urandom_range(0, 99) < 60);
            mem_resp_valid_i = ($urandom_range(0, 99) < 30);
            mem_resp_data_i  = {$urandom, $urandom};
            reset            = ($urandom_range(0, 99) >= 2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
